// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the main controller and the iterative MULT/DIV engine.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op_div, a, b,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op_div, a, b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed radix-2 MULT/DIV engine; one shared shift/add-subtract datapath
// on W+1-bit magnitudes, signs applied in FIX, results held in Hi/Lo.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_count;
    logic               r_op_div, r_neg_res, r_neg_dvd, r_dz;
    logic [WIDTH:0]     r_acc, r_mag_b;
    logic [WIDTH-1:0]   r_mq, r_hi, r_lo;

    logic [WIDTH:0]     w_ext_a, w_ext_b, w_abs_a, w_abs_b;
    logic               w_b_zero, w_last;
    logic [WIDTH:0]     w_shift, w_add_a, w_add_b;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_hi_fix, w_lo_fix;

    assign w_ext_a  = {bus.a[WIDTH-1], bus.a};
    assign w_ext_b  = {bus.b[WIDTH-1], bus.b};
    assign w_abs_a  = w_ext_a[WIDTH] ? -w_ext_a : w_ext_a;
    assign w_abs_b  = w_ext_b[WIDTH] ? -w_ext_b : w_ext_b;
    assign w_b_zero = (bus.b == '0);
    assign w_last   = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = (bus.op_div && w_b_zero) ? S_DONE : S_RUN;
            S_RUN:  if (w_last) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (r_state != S_IDLE);
        bus.done     = (r_state == S_DONE);
        bus.div_zero = (r_state == S_DONE) && r_dz;
        bus.hi       = r_hi;
        bus.lo       = r_lo;
    end

    // Mult adds |b| when the low multiplier bit is set then shifts right;
    // div shifts left and subtracts |b|, keeping the difference if non-negative.
    always_comb begin
        w_shift = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
        w_add_a = r_op_div ? w_shift : r_acc;
        w_add_b = (r_op_div || r_mq[0]) ? r_mag_b : '0;
        w_sum   = r_op_div ? ({1'b0, w_add_a} - {1'b0, w_add_b})
                           : ({1'b0, w_add_a} + {1'b0, w_add_b});
        if (r_op_div) begin
            w_acc_nxt = w_sum[WIDTH+1] ? w_shift : w_sum[WIDTH:0];
            w_mq_nxt  = {r_mq[WIDTH-2:0], ~w_sum[WIDTH+1]};
        end else begin
            w_acc_nxt = w_sum[WIDTH+1:1];
            w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod   = {r_acc[WIDTH-1:0], r_mq};
        w_prod_s = r_neg_res ? -w_prod : w_prod;
        if (r_op_div) begin
            w_lo_fix = r_neg_res ? -r_mq : r_mq;
            w_hi_fix = r_neg_dvd ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else begin
            w_lo_fix = w_prod_s[WIDTH-1:0];
            w_hi_fix = w_prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_op_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_dvd <= 1'b0;
            r_dz      <= 1'b0;
            r_acc     <= '0;
            r_mag_b   <= '0;
            r_mq      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_op_div  <= bus.op_div;
                    r_neg_res <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    r_neg_dvd <= bus.a[WIDTH-1];
                    r_dz      <= bus.op_div && w_b_zero;
                    r_mq      <= w_abs_a[WIDTH-1:0];
                    r_mag_b   <= w_abs_b;
                    r_acc     <= '0;
                    r_count   <= '0;
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_mq    <= w_mq_nxt;
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: signed mult/div vectors, latency,
// divide-by-zero, start overlap, operand stability and asynchronous reset.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request in the current cycle (cycle 0) and waits for done.
    // lat is the cycle index of the done pulse; busy_cnt counts busy cycles before it.
    task automatic do_op(input logic op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit scramble, output int lat, output int busy_cnt, output logic dz);
        bus.start  = 1'b1;
        bus.op_div = op;
        bus.a      = aa;
        bus.b      = bb;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            if (scramble && lat == 5) begin
                bus.a      = 32'h0000DEAD;
                bus.b      = 32'hFFFFFFF3;
                bus.op_div = ~op;
            end
            @(negedge clk);
            lat++;
        end
        dz = bus.div_zero;
        @(negedge clk);
    endtask

    int          lat, bcnt, ndone;
    logic        dz;
    int          pulses[$];

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz",   64'(bus.div_zero), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, lat, bcnt, dz);
        chk("mul_7x-3",     {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        chk("mul_latency",  64'(lat),  64'd34);
        chk("mul_busy_cyc", 64'(bcnt), 64'd33);
        chk("mul_no_dz",    64'(dz),   64'd0);
        chk("idle_after",   64'(bus.busy), 64'd0);

        do_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, lat, bcnt, dz);
        chk("mul_extreme", {bus.hi, bus.lo}, 64'h40000000_00000000);

        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bcnt, dz);
        chk("div_-7/2", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        chk("div_latency", 64'(lat), 64'd34);

        do_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, lat, bcnt, dz);
        chk("div_7/-2", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFD);

        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bcnt, dz);
        chk("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);

        do_op(1'b1, 32'h56781234, 32'h00010000, 1'b0, lat, bcnt, dz);
        chk("div_setup", {bus.hi, bus.lo}, 64'h00001234_00005678);

        do_op(1'b1, 32'd5, 32'd0, 1'b0, lat, bcnt, dz);
        chk("dz_latency", 64'(lat), 64'd1);
        chk("dz_flag",    64'(dz),  64'd1);
        chk("dz_hilo",    {bus.hi, bus.lo}, 64'h00001234_00005678);
        chk("dz_cleared", 64'(bus.div_zero), 64'd0);

        do_op(1'b0, 32'd5, 32'd0, 1'b0, lat, bcnt, dz);
        chk("mul_b0",    {bus.hi, bus.lo}, 64'd0);
        chk("mul_b0_dz", 64'(dz), 64'd0);

        do_op(1'b0, 32'd100, 32'd200, 1'b1, lat, bcnt, dz);
        chk("mul_scramble", {bus.hi, bus.lo}, 64'd20000);
        chk("scr_latency",  64'(lat), 64'd34);

        // start held high: second accept happens the cycle after DONE
        bus.start  = 1'b1;
        bus.op_div = 1'b0;
        bus.a      = 32'd3;
        bus.b      = 32'd5;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus.done) pulses.push_back(c);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("ovl_count", 64'(pulses.size()), 64'd2);
        if (pulses.size() >= 2) begin
            chk("ovl_first",  64'(pulses[0]), 64'd34);
            chk("ovl_second", 64'(pulses[1]), 64'd69);
        end
        chk("ovl_result", {bus.hi, bus.lo}, 64'd15);

        bus.start  = 1'b1;
        bus.op_div = 1'b0;
        bus.a      = 32'd9;
        bus.b      = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);

        do_op(1'b0, 32'hFFFFFFFB, 32'd6, 1'b0, lat, bcnt, dz);
        chk("mul_after_rst", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFE2);
        chk("lat_after_rst", 64'(lat), 64'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
